// File: rtl/stream_xbar_pkg.sv
// stream_xbar_pkg: shared arbiter state type and FIFO entry width helper for the stream crossbar.
package stream_xbar_pkg;

   typedef enum logic {IDLE, LOCKED} arb_state_e;

   // Entry layout is {data, last, source id}.
   function automatic int entry_width(input int data_w, input int id_w);
      return data_w + 1 + id_w;
   endfunction

endpackage

// File: rtl/stream_fifo.sv
// stream_fifo: count-based synchronous FIFO; outputs read zero while empty.
module stream_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full_o  = cnt_q == (AW+1)'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign data_o  = empty_o ? '0 : mem_q[rd_q];

   always_comb begin
      wr_d  = do_push ? wr_q + 1'b1 : wr_q;
      rd_d  = do_pop ? rd_q + 1'b1 : rd_q;
      cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) if (do_push) mem_q[wr_q] <= data_i;

endmodule

// File: rtl/stream_xbar_buf.sv
// stream_xbar_buf: packet crossbar with per-output round-robin arbiter locked for a whole packet
// and a buffering FIFO on every output; out-of-range destinations are dropped.
module stream_xbar_buf
   import stream_xbar_pkg::*;
#(
   parameter int T_DATA_WIDTH = 8,
   parameter int S_DATA_COUNT = 2,
   parameter int M_DATA_COUNT = 3,
   parameter int FIFO_DEPTH   = 4,
   localparam int T_DEST_WIDTH = $clog2(M_DATA_COUNT),
   localparam int T_ID_WIDTH   = $clog2(S_DATA_COUNT)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [T_DATA_WIDTH-1:0] s_data_i [S_DATA_COUNT],
   input  logic [T_DEST_WIDTH-1:0] s_dest_i [S_DATA_COUNT],
   input  logic [S_DATA_COUNT-1:0] s_last_i,
   input  logic [S_DATA_COUNT-1:0] s_valid_i,
   output logic [S_DATA_COUNT-1:0] s_ready_o,
   output logic [S_DATA_COUNT-1:0] drop_o,
   output logic [T_DATA_WIDTH-1:0] m_data_o [M_DATA_COUNT],
   output logic [T_ID_WIDTH-1:0]   m_id_o [M_DATA_COUNT],
   output logic [M_DATA_COUNT-1:0] m_last_o,
   output logic [M_DATA_COUNT-1:0] m_valid_o,
   input  logic [M_DATA_COUNT-1:0] m_ready_i
);

   localparam int EW = entry_width(T_DATA_WIDTH, T_ID_WIDTH);

   arb_state_e              state_q [M_DATA_COUNT], state_d [M_DATA_COUNT];
   logic [T_ID_WIDTH-1:0]   rr_q [M_DATA_COUNT], rr_d [M_DATA_COUNT];
   logic [T_ID_WIDTH-1:0]   gnt_q [M_DATA_COUNT], gnt_d [M_DATA_COUNT];
   logic [S_DATA_COUNT-1:0] req [M_DATA_COUNT];
   logic [S_DATA_COUNT-1:0] busy;
   logic [M_DATA_COUNT-1:0] push, full, empty;
   logic [EW-1:0]           wdata [M_DATA_COUNT], rdata [M_DATA_COUNT];

   // First requester at or above rr, wrapping; lowest offset wins.
   function automatic logic [T_ID_WIDTH-1:0] pick(input logic [S_DATA_COUNT-1:0] r,
                                                  input logic [T_ID_WIDTH-1:0] rr);
      logic [T_ID_WIDTH-1:0] idx;
      pick = rr;
      for (int i = S_DATA_COUNT-1; i >= 0; i--) begin
         idx = T_ID_WIDTH'((int'(rr) + i) % S_DATA_COUNT);
         if (r[idx]) pick = idx;
      end
   endfunction

   // A source locked to any output is invisible to the other arbiters.
   always_comb begin
      busy = '0;
      for (int o = 0; o < M_DATA_COUNT; o++) if (state_q[o] == LOCKED) busy[gnt_q[o]] = 1'b1;
      for (int o = 0; o < M_DATA_COUNT; o++)
         for (int s = 0; s < S_DATA_COUNT; s++)
            req[o][s] = s_valid_i[s] && !busy[s] && int'(s_dest_i[s]) == o;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= '{default: IDLE};
         rr_q    <= '{default: '0};
         gnt_q   <= '{default: '0};
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         gnt_q   <= gnt_d;
      end
   end

   always_comb begin
      for (int o = 0; o < M_DATA_COUNT; o++) begin
         state_d[o] = state_q[o];
         rr_d[o]    = rr_q[o];
         gnt_d[o]   = gnt_q[o];
         if (state_q[o] == IDLE && |req[o]) begin
            state_d[o] = LOCKED;
            gnt_d[o]   = pick(req[o], rr_q[o]);
         end else if (state_q[o] == LOCKED && push[o] && s_last_i[gnt_q[o]]) begin
            state_d[o] = IDLE;
            rr_d[o]    = T_ID_WIDTH'((int'(gnt_q[o]) + 1) % S_DATA_COUNT);
         end
      end
   end

   always_comb begin
      s_ready_o = '0;
      drop_o    = '0;
      for (int s = 0; s < S_DATA_COUNT; s++)
         if (!busy[s] && int'(s_dest_i[s]) >= M_DATA_COUNT) begin
            s_ready_o[s] = !rst;
            drop_o[s]    = !rst && s_valid_i[s];
         end
      for (int o = 0; o < M_DATA_COUNT; o++) begin
         push[o]  = state_q[o] == LOCKED && s_valid_i[gnt_q[o]] && !full[o];
         wdata[o] = {s_data_i[gnt_q[o]], s_last_i[gnt_q[o]], gnt_q[o]};
         if (state_q[o] == LOCKED) s_ready_o[gnt_q[o]] = !full[o];
      end
   end

   for (genvar g = 0; g < M_DATA_COUNT; g++) begin : g_out
      stream_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .push_i  (push[g]),
         .pop_i   (m_ready_i[g]),
         .data_i  (wdata[g]),
         .data_o  (rdata[g]),
         .full_o  (full[g]),
         .empty_o (empty[g])
      );
      assign m_valid_o[g] = !empty[g];
      assign {m_data_o[g], m_last_o[g], m_id_o[g]} = rdata[g];
   end

endmodule

// File: tb/tb_stream_xbar_buf.sv
// tb_stream_xbar_buf: cycle-by-cycle vector table plus hand sequences for backpressure and reset.
module tb_stream_xbar_buf;

   logic       clk = 1'b0, rst = 1'b1;
   logic [7:0] s_data [2];
   logic [1:0] s_dest [2];
   logic [1:0] s_last, s_valid, s_ready, drop;
   logic [7:0] m_data [3];
   logic [0:0] m_id [3];
   logic [2:0] m_last, m_valid, m_ready;
   int         pas = 0, tot = 0;

   stream_xbar_buf dut (
      .clk(clk), .rst(rst),
      .s_data_i(s_data), .s_dest_i(s_dest), .s_last_i(s_last), .s_valid_i(s_valid),
      .s_ready_o(s_ready), .drop_o(drop),
      .m_data_o(m_data), .m_id_o(m_id), .m_last_o(m_last), .m_valid_o(m_valid),
      .m_ready_i(m_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] sv, sl, d0, d1;
      logic [7:0] x0, x1;
      logic [1:0] er, edr;
      logic [2:0] ev, el;
      logic [7:0] e0, e1, e2;
      logic [2:0] eid;
   } vec_t;

   vec_t vecs[22];

   function automatic vec_t v(logic [1:0] sv, sl, d0, d1, logic [7:0] x0, x1, logic [1:0] er, edr,
                              logic [2:0] ev, el, logic [7:0] e0, e1, e2, logic [2:0] eid);
      return '{sv, sl, d0, d1, x0, x1, er, edr, ev, el, e0, e1, e2, eid};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tot++;
      if (act === exp) pas++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int         idx, np;
      logic [7:0] got [8];
      logic       gl [8];
      logic [0:0] gid [8];
      logic [1:0] pend;
      logic [7:0] exp_d [3];
      vecs[0]  = v(2'b01, 2'b00, 0, 0, 8'hAA, 8'h00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0, 0);
      vecs[1]  = v(2'b01, 2'b00, 0, 0, 8'hAA, 8'h00, 2'b01, 2'b00, 3'b000, 3'b000, 0, 0, 0, 0);
      vecs[2]  = v(2'b01, 2'b01, 0, 0, 8'hAB, 8'h00, 2'b01, 2'b00, 3'b001, 3'b000, 8'hAA, 0, 0, 0);
      vecs[3]  = v(2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 2'b00, 2'b00, 3'b001, 3'b001, 8'hAB, 0, 0, 0);
      vecs[4]  = v(2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0, 0);
      vecs[5]  = v(2'b11, 2'b11, 0, 0, 8'hAA, 8'hBB, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0, 0);
      vecs[6]  = v(2'b11, 2'b11, 0, 0, 8'hAA, 8'hBB, 2'b10, 2'b00, 3'b000, 3'b000, 0, 0, 0, 0);
      vecs[7]  = v(2'b01, 2'b01, 0, 0, 8'hAA, 8'h00, 2'b00, 2'b00, 3'b001, 3'b001, 8'hBB, 0, 0, 3'b001);
      vecs[8]  = v(2'b01, 2'b01, 0, 0, 8'hAA, 8'h00, 2'b01, 2'b00, 3'b000, 3'b000, 0, 0, 0, 0);
      vecs[9]  = v(2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 2'b00, 2'b00, 3'b001, 3'b001, 8'hAA, 0, 0, 0);
      vecs[10] = v(2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0, 0);
      vecs[11] = v(2'b11, 2'b11, 1, 2, 8'h11, 8'h22, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0, 0);
      vecs[12] = v(2'b11, 2'b11, 1, 2, 8'h11, 8'h22, 2'b11, 2'b00, 3'b000, 3'b000, 0, 0, 0, 0);
      vecs[13] = v(2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 2'b00, 2'b00, 3'b110, 3'b110, 0, 8'h11, 8'h22, 3'b100);
      vecs[14] = v(2'b10, 2'b00, 0, 3, 8'h00, 8'h33, 2'b10, 2'b10, 3'b000, 3'b000, 0, 0, 0, 0);
      vecs[15] = v(2'b10, 2'b10, 0, 3, 8'h00, 8'h34, 2'b10, 2'b10, 3'b000, 3'b000, 0, 0, 0, 0);
      vecs[16] = v(2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0, 0);
      vecs[17] = v(2'b01, 2'b00, 2, 0, 8'h41, 8'h00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0, 0);
      vecs[18] = v(2'b01, 2'b00, 2, 0, 8'h41, 8'h00, 2'b01, 2'b00, 3'b000, 3'b000, 0, 0, 0, 0);
      vecs[19] = v(2'b00, 2'b00, 1, 0, 8'h00, 8'h00, 2'b01, 2'b00, 3'b100, 3'b000, 0, 0, 8'h41, 0);
      vecs[20] = v(2'b01, 2'b01, 1, 0, 8'h42, 8'h00, 2'b01, 2'b00, 3'b000, 3'b000, 0, 0, 0, 0);
      vecs[21] = v(2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 2'b00, 2'b00, 3'b100, 3'b100, 0, 0, 8'h42, 0);

      // Reset state, with a bad-destination request that must stay masked.
      s_data = '{8'h00, 8'h77};
      s_dest = '{2'd0, 2'd3};
      s_last = 2'b00;
      s_valid = 2'b10;
      m_ready = 3'b111;
      repeat (2) @(negedge clk);
      #2;
      chk("rst s_ready", s_ready, 0);
      chk("rst drop", drop, 0);
      chk("rst m_valid", m_valid, 0);
      chk("rst m_last", m_last, 0);
      chk("rst m_data", {m_data[0], m_data[1], m_data[2]}, 0);
      chk("rst m_id", {m_id[0], m_id[1], m_id[2]}, 0);
      @(negedge clk);
      rst = 1'b0;
      s_valid = 2'b00;
      s_dest = '{2'd0, 2'd0};

      foreach (vecs[k]) begin
         @(negedge clk);
         s_valid = vecs[k].sv;
         s_last = vecs[k].sl;
         s_dest = '{vecs[k].d0, vecs[k].d1};
         s_data = '{vecs[k].x0, vecs[k].x1};
         m_ready = 3'b111;
         #2;
         exp_d = '{vecs[k].e0, vecs[k].e1, vecs[k].e2};
         chk($sformatf("v%0d s_ready", k), s_ready, vecs[k].er);
         chk($sformatf("v%0d drop", k), drop, vecs[k].edr);
         chk($sformatf("v%0d m_valid", k), m_valid, vecs[k].ev);
         chk($sformatf("v%0d m_last", k), m_last, vecs[k].el);
         for (int o = 0; o < 3; o++) begin
            chk($sformatf("v%0d m_data[%0d]", k, o), m_data[o], exp_d[o]);
            chk($sformatf("v%0d m_id[%0d]", k, o), m_id[o], vecs[k].eid[o]);
         end
      end

      // Backpressure: output 0 stalled for 10 cycles while src0 streams 6 beats.
      idx = 0;
      np = 0;
      s_dest = '{2'd0, 2'd0};
      s_valid = 2'b00;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         m_ready = (c >= 10) ? 3'b111 : 3'b110;
         s_valid[0] = idx < 6;
         s_data[0] = 8'h50 + 8'(idx);
         s_last[0] = idx == 5;
         #2;
         if (c == 9) begin
            chk("bp accepted", idx, 4);
            chk("bp s_ready", s_ready[0], 0);
            chk("bp m_valid", m_valid[0], 1);
         end
         if (m_valid[0] && m_ready[0] && np < 8) begin
            got[np] = m_data[0];
            gl[np] = m_last[0];
            np++;
         end
         if (s_valid[0] && s_ready[0]) idx++;
      end
      chk("bp delivered", np, 6);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("bp data%0d", i), got[i], 8'h50 + 8'(i));
         chk($sformatf("bp last%0d", i), gl[i], i == 5);
      end

      // Reset mid-packet: two of four beats buffered, then reset and a fresh contention.
      idx = 0;
      m_ready = 3'b110;
      for (int c = 0; c < 10 && idx < 2; c++) begin
         @(negedge clk);
         s_valid[0] = 1'b1;
         s_data[0] = 8'h60 + 8'(idx);
         s_last[0] = 1'b0;
         #2;
         if (s_valid[0] && s_ready[0]) idx++;
      end
      chk("mid idx", idx, 2);
      @(negedge clk);
      chk("mid m_valid pre", m_valid[0], 1);
      rst = 1'b1;
      #2;
      chk("mid rst m_valid", m_valid, 0);
      chk("mid rst s_ready", s_ready, 0);
      chk("mid rst m_data", m_data[0], 0);
      @(negedge clk);
      chk("mid after m_valid", m_valid, 0);
      rst = 1'b0;
      pend = 2'b11;
      s_valid = pend;
      s_last = 2'b11;
      s_dest = '{2'd0, 2'd0};
      s_data = '{8'hAA, 8'hBB};
      m_ready = 3'b111;
      np = 0;
      for (int c = 0; c < 20 && np < 2; c++) begin
         #2;
         if (m_valid[0] && np < 8) begin
            got[np] = m_data[0];
            gid[np] = m_id[0];
            np++;
         end
         pend = pend & ~(s_valid & s_ready);
         @(negedge clk);
         s_valid = pend;
      end
      chk("post count", np, 2);
      chk("post data0", got[0], 8'hAA);
      chk("post id0", gid[0], 0);
      chk("post data1", got[1], 8'hBB);
      chk("post id1", gid[1], 1);

      $display("%0d/%0d checks passed", pas, tot);
      $finish;
   end

endmodule
